// File: rtl/bw_io_dtl_drv_seq.sv
// Drive-leg sequencer for one DTL pad: break-before-make sequencing of the
// pull-up and pull-down legs, plus a 2-bit boundary-scan capture/shift/update path.
module bw_io_dtl_drv_seq #(
    parameter int DEAD_CYC = 2,
    parameter int CNT_W    = 3
) (
    input  logic clk,
    input  logic rst_l,
    input  logic oe,
    input  logic data,
    input  logic term_en,
    input  logic bs_mode,
    input  logic bs_capture,
    input  logic bs_shift,
    input  logic bs_update,
    input  logic bs_si,
    output logic bs_so,
    input  logic intest_oe,
    input  logic intest_d,
    output logic q_up_pad,
    output logic q_dn_pad,
    output logic q25_dn_pad,
    output logic busy
);

    // State encoding equals the leg pattern {q_up_pad, q_dn_pad, q25_dn_pad},
    // so the pad legs come straight off flops with no decode glitches.
    typedef enum logic [2:0] {
        ST_OFF  = 3'b011,
        ST_TERM = 3'b010,
        ST_DRV1 = 3'b111,
        ST_DRV0 = 3'b000
    } leg_t;

    leg_t             state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [1:0]       sr_q;
    logic [1:0]       upd_q;

    logic eoe_s;
    logic ed_s;
    leg_t target_s;
    logic conflict_s;

    // Effective request, leg target and conflict detection.
    always_comb begin
        eoe_s      = 1'b0;
        ed_s       = 1'b0;
        target_s   = ST_OFF;
        conflict_s = 1'b0;
        if (bs_mode) begin
            eoe_s = upd_q[1];
            ed_s  = upd_q[0];
        end else begin
            eoe_s = oe;
            ed_s  = data;
        end
        case ({eoe_s, ed_s, term_en})
            3'b110, 3'b111: target_s = ST_DRV1;
            3'b100, 3'b101: target_s = ST_DRV0;
            3'b001, 3'b011: target_s = ST_TERM;
            default:        target_s = ST_OFF;
        endcase
        // Pull-up against either pull-down leg must pass through OFF.
        if ((state_q == ST_DRV1) && ((target_s == ST_DRV0) || (target_s == ST_TERM))) begin
            conflict_s = 1'b1;
        end else if (((state_q == ST_DRV0) || (state_q == ST_TERM)) && (target_s == ST_DRV1)) begin
            conflict_s = 1'b1;
        end else begin
            conflict_s = 1'b0;
        end
    end

    // Leg FSM with dead-time counter.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q <= ST_OFF;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
        end else if (busy_q) begin
            if (cnt_q == {CNT_W{1'b0}}) begin
                busy_q  <= 1'b0;
                state_q <= target_s;
            end else begin
                cnt_q   <= cnt_q - CNT_W'(1);
                state_q <= ST_OFF;
            end
        end else if (target_s == state_q) begin
            state_q <= state_q;
        end else if (conflict_s) begin
            state_q <= ST_OFF;
            cnt_q   <= CNT_W'(DEAD_CYC - 1);
            busy_q  <= 1'b1;
        end else begin
            state_q <= target_s;
        end
    end

    // Boundary-scan shift and update registers; update copies the pre-edge sr.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            sr_q  <= 2'b00;
            upd_q <= 2'b00;
        end else begin
            if (bs_capture) begin
                sr_q <= {intest_oe, intest_d};
            end else if (bs_shift) begin
                sr_q <= {sr_q[0], bs_si};
            end else begin
                sr_q <= sr_q;
            end
            if (bs_update) begin
                upd_q <= sr_q;
            end else begin
                upd_q <= upd_q;
            end
        end
    end

    assign q_up_pad   = state_q[2];
    assign q_dn_pad   = state_q[1];
    assign q25_dn_pad = state_q[0];
    assign busy       = busy_q;
    assign bs_so      = sr_q[1];

endmodule

// File: tb/tb_bw_io_dtl_drv_seq.sv
// Scoreboard bench for bw_io_dtl_drv_seq: directed vectors push expected
// {up,dn,d25,busy,so} per edge; a negedge monitor pops, compares and checks the leg invariant.
module tb_bw_io_dtl_drv_seq;

    logic clk = 1'b0;
    logic rst_l, oe, data, term_en, bs_mode, bs_capture, bs_shift, bs_update, bs_si;
    logic intest_oe, intest_d;
    logic bs_so, q_up_pad, q_dn_pad, q25_dn_pad, busy;

    bw_io_dtl_drv_seq #(.DEAD_CYC(2), .CNT_W(3)) dut (
        .clk(clk), .rst_l(rst_l), .oe(oe), .data(data), .term_en(term_en),
        .bs_mode(bs_mode), .bs_capture(bs_capture), .bs_shift(bs_shift),
        .bs_update(bs_update), .bs_si(bs_si), .bs_so(bs_so),
        .intest_oe(intest_oe), .intest_d(intest_d),
        .q_up_pad(q_up_pad), .q_dn_pad(q_dn_pad), .q25_dn_pad(q25_dn_pad), .busy(busy)
    );

    always #5 clk = ~clk;

    // Expected leg patterns {up,dn,d25}
    localparam logic [2:0] OFF  = 3'b011;
    localparam logic [2:0] TERM = 3'b010;
    localparam logic [2:0] DRV1 = 3'b111;
    localparam logic [2:0] DRV0 = 3'b000;

    string      nm_q[$];
    logic [4:0] ex_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Monitor: invariant every cycle, scoreboard entry whenever one is pending.
    always @(negedge clk) begin
        logic [4:0] act;
        logic [4:0] exp;
        string      nm;
        n_checks++;
        if (q_up_pad && (!q_dn_pad || !q25_dn_pad))
            $display("FAIL leg_overlap t=%0t actual up/dn/d25=%b%b%b required no pull-up with pull-down",
                     $time, q_up_pad, q_dn_pad, q25_dn_pad);
        else
            n_pass++;
        if (ex_q.size() > 0) begin
            exp = ex_q.pop_front();
            nm  = nm_q.pop_front();
            act = {q_up_pad, q_dn_pad, q25_dn_pad, busy, bs_so};
            n_checks++;
            if (act !== exp)
                $display("FAIL %s actual up,dn,d25,busy,so=%b required %b", nm, act, exp);
            else
                n_pass++;
        end
    end

    task automatic step(input string nm, input logic [2:0] leg, input logic b, input logic so);
        @(posedge clk);
        nm_q.push_back(nm);
        ex_q.push_back({leg, b, so});
        @(negedge clk);
    endtask

    initial begin
        rst_l = 1'b0; oe = 1'b1; data = 1'b1; term_en = 1'b0; bs_mode = 1'b0;
        bs_capture = 1'b0; bs_shift = 1'b0; bs_update = 1'b0; bs_si = 1'b0;
        intest_oe = 1'b0; intest_d = 1'b0;

        // 1: reset holds OFF, first edge after release honors request
        step("rst_a", OFF, 1'b0, 1'b0);
        step("rst_b", OFF, 1'b0, 1'b0);
        rst_l = 1'b1;
        step("rel_drv1", DRV1, 1'b0, 1'b0);

        // 2: DRV1 -> DRV0 through two dead cycles
        data = 1'b0;
        step("dt1_a", OFF, 1'b1, 1'b0);
        step("dt1_b", OFF, 1'b1, 1'b0);
        step("to_drv0", DRV0, 1'b0, 1'b0);
        step("hold_drv0", DRV0, 1'b0, 1'b0);

        // 3: DRV0 -> TERM direct, TERM -> DRV1 via dead time
        oe = 1'b0; term_en = 1'b1;
        step("to_term", TERM, 1'b0, 1'b0);
        oe = 1'b1; data = 1'b1;
        step("dt2_a", OFF, 1'b1, 1'b0);
        step("dt2_b", OFF, 1'b1, 1'b0);
        step("to_drv1", DRV1, 1'b0, 1'b0);

        // 4: request drops to OFF during dead time
        data = 1'b0;
        step("dt3_a", OFF, 1'b1, 1'b0);
        oe = 1'b0; term_en = 1'b0;
        step("dt3_b", OFF, 1'b1, 1'b0);
        step("dt3_end", OFF, 1'b0, 1'b0);
        step("dt3_stay", OFF, 1'b0, 1'b0);
        oe = 1'b1;
        step("off_drv0", DRV0, 1'b0, 1'b0);
        oe = 1'b0;
        step("drv0_off", OFF, 1'b0, 1'b0);

        // 5: scan capture / shift / update / mode
        bs_capture = 1'b1; intest_oe = 1'b1; intest_d = 1'b0;
        step("cap10", OFF, 1'b0, 1'b1);
        bs_capture = 1'b0; bs_shift = 1'b1; bs_si = 1'b1;
        step("sh01", OFF, 1'b0, 1'b0);
        step("sh11", OFF, 1'b0, 1'b1);
        bs_shift = 1'b0; bs_update = 1'b1;
        step("upd11", OFF, 1'b0, 1'b1);
        bs_update = 1'b0; bs_mode = 1'b1;
        step("bs_drv1", DRV1, 1'b0, 1'b1);
        bs_capture = 1'b1; bs_shift = 1'b1; intest_oe = 1'b0; intest_d = 1'b1; bs_si = 1'b1;
        step("cap_wins", DRV1, 1'b0, 1'b0);
        bs_capture = 1'b0; bs_shift = 1'b0; bs_update = 1'b1;
        step("upd01_edge", DRV1, 1'b0, 1'b0);
        bs_update = 1'b0;
        step("upd01_off", OFF, 1'b0, 1'b0);
        bs_capture = 1'b1; bs_update = 1'b1; intest_oe = 1'b1; intest_d = 1'b1;
        step("cap_upd_pre", OFF, 1'b0, 1'b1);
        bs_capture = 1'b0; bs_update = 1'b0;
        step("upd_old_kept", OFF, 1'b0, 1'b1);
        bs_update = 1'b1;
        step("upd11_edge", OFF, 1'b0, 1'b1);
        bs_update = 1'b0;
        step("upd11_drv1", DRV1, 1'b0, 1'b1);

        // 6: reset mid-dead-time, then clears sr/upd
        bs_mode = 1'b0; oe = 1'b1; data = 1'b0;
        step("dt4_a", OFF, 1'b1, 1'b1);
        rst_l = 1'b0;
        step("rst_mid", OFF, 1'b0, 1'b0);
        rst_l = 1'b1; oe = 1'b1; data = 1'b1;
        step("post_rst", DRV1, 1'b0, 1'b0);
        bs_mode = 1'b1;
        step("upd_cleared", OFF, 1'b0, 1'b0);

        // Random stress: invariant checked by the monitor every cycle
        for (int i = 0; i < 400; i++) begin
            rst_l      = ($urandom_range(0, 49) != 0);
            oe         = 1'($urandom_range(0, 1));
            data       = 1'($urandom_range(0, 1));
            term_en    = 1'($urandom_range(0, 1));
            bs_mode    = 1'($urandom_range(0, 1));
            bs_capture = 1'($urandom_range(0, 1));
            bs_shift   = 1'($urandom_range(0, 1));
            bs_update  = 1'($urandom_range(0, 1));
            bs_si      = 1'($urandom_range(0, 1));
            intest_oe  = 1'($urandom_range(0, 1));
            intest_d   = 1'($urandom_range(0, 1));
            @(negedge clk);
        end

        for (int i = 0; i < 10 && ex_q.size() > 0; i++) @(negedge clk);
        if (ex_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain actual pending=%0d required 0", ex_q.size());
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
